// File: rtl/raster_timing_pkg.sv
// Shared timing defaults and output-decode helpers for the raster timing generator.
// Defaults describe 640x480 at 60 Hz with a 2:1 clock-to-pixel ratio.
package raster_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned DIV_DEF = 2;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned CNT_W = 10;

    // True while cnt lies in [lo, lo+len-1].
    function automatic logic in_window(logic [CNT_W-1:0] cnt, int unsigned lo, int unsigned len);
        return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/raster_timing_if.sv
// Raster output bundle: syncs, active-area coordinates and timing strobes.
interface raster_timing_if;

    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel;
    logic [8:0] line;
    logic       pix_tick;
    logic       frame_start;

    modport master (
        output hsync, vsync, video_on, pixel, line, pix_tick, frame_start
    );

    modport slave (
        input hsync, vsync, video_on, pixel, line, pix_tick, frame_start
    );

endinterface

// File: rtl/raster_timing_pix_tick_gen.sv
// Pixel-rate divider: pix_step is the advance condition for the edge that raises
// the registered pix_tick strobe, so counters and strobe move on the same edge.
module pix_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_step,
    output logic pix_tick
);

    localparam logic [1:0] DivLast = 2'(DIV - 1);

    logic [1:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;

    always_comb begin
        pix_step = (cnt_q == DivLast);
        cnt_d    = pix_step ? 2'd0 : cnt_q + 2'd1;
        tick_d   = pix_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign pix_tick = tick_q;

endmodule

// File: rtl/raster_timing.sv
// Raster timing generator: horizontal/vertical counters with registered sync,
// active-area and coordinate outputs decoded from the counters' next state.
module raster_timing
    import raster_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned DIV      = DIV_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    raster_timing_if.master vid
);

    localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] HLast = CNT_W'(HTot - 1);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(VTot - 1);

    if (H_ACTIVE > 1023 || V_ACTIVE > 511 || DIV < 1 || DIV > 4 ||
        HTot > 1024 || VTot > 1024) begin : g_param_check
        $error("raster_timing: illegal timing parameters");
    end

    logic pix_step;
    logic pix_tick;

    pix_tick_gen #(
        .DIV(DIV)
    ) u_pix_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_step(pix_step),
        .pix_tick(pix_tick)
    );

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [9:0]       pixel_q, pixel_d;
    logic [8:0]       line_q, line_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;

        if (pix_step) begin
            if (hcount_q == HLast) begin
                hcount_d = '0;
                if (vcount_q == VLast) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Decoding the next count keeps every output aligned with the counters.
        video_on_d = (32'(hcount_d) < H_ACTIVE) && (32'(vcount_d) < V_ACTIVE);
        hsync_d    = !in_window(hcount_d, H_ACTIVE + H_FP, H_SYNC);
        vsync_d    = !in_window(vcount_d, V_ACTIVE + V_FP, V_SYNC);
        pixel_d    = video_on_d ? hcount_d : '0;
        line_d     = video_on_d ? vcount_d[8:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_q       <= '0;
            line_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_q       <= pixel_d;
            line_q        <= line_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.video_on    = video_on_q;
    assign vid.pixel       = pixel_q;
    assign vid.line        = line_q;
    assign vid.pix_tick    = pix_tick;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_raster_timing.sv
// Bench for raster_timing: three parameterisations checked every cycle against a
// pixel-count arithmetic model, with random asynchronous reset pulses.
module tb_raster_timing;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic [9:0] pixel;
        logic [8:0] line;
        logic       pix_tick;
        logic       frame_start;
    } obs_t;

    // A: small frame 25x13, DIV=2.  B: default timing, DIV=1.  C: small frame 16x10, DIV=4.
    localparam int A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 4;
    localparam int A_VA = 8,  A_VF = 1, A_VS = 2, A_VB = 2, A_DIV = 2;
    localparam int C_HA = 10, C_HF = 1, C_HS = 2, C_HB = 3;
    localparam int C_VA = 6,  C_VF = 1, C_VS = 1, C_VB = 2, C_DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic run_chk = 1'b0;
    int   k = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    raster_timing_if if_a ();
    raster_timing_if if_b ();
    raster_timing_if if_c ();

    raster_timing #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .DIV(A_DIV)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (if_a)
    );

    raster_timing #(
        .DIV(1)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (if_b)
    );

    raster_timing #(
        .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
        .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB), .DIV(C_DIV)
    ) u_dut_c (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (if_c)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {if_a.hsync, if_a.vsync, if_a.video_on, if_a.pixel, if_a.line,
                    if_a.pix_tick, if_a.frame_start};
    assign obs_b = {if_b.hsync, if_b.vsync, if_b.video_on, if_b.pixel, if_b.line,
                    if_b.pix_tick, if_b.frame_start};
    assign obs_c = {if_c.hsync, if_c.vsync, if_c.video_on, if_c.pixel, if_c.line,
                    if_c.pix_tick, if_c.frame_start};

    // Clock edges seen since reset was last released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Outputs after k edges: n = k/div pixel steps taken, position is n modulo the frame.
    function automatic obs_t exp_out(int kk, int div, int ha, int hf, int hs, int hb,
                                     int va, int vf, int vs, int vb);
        obs_t e;
        int ht, vt, n, h, v;
        e = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        if (kk == 0) return e;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        n  = kk / div;
        h  = n % ht;
        v  = (n / ht) % vt;
        e.pix_tick    = (kk % div == 0);
        e.frame_start = e.pix_tick && (n > 0) && (n % (ht * vt) == 0);
        e.hsync       = !(h >= ha + hf && h < ha + hf + hs);
        e.vsync       = !(v >= va + vf && v < va + vf + vs);
        e.video_on    = (h < ha) && (v < va);
        e.pixel       = e.video_on ? 10'(h) : 10'd0;
        e.line        = e.video_on ? 9'(v) : 9'd0;
        return e;
    endfunction

    function automatic obs_t exp_a(int kk);
        return exp_out(kk, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB);
    endfunction

    function automatic obs_t exp_b(int kk);
        return exp_out(kk, 1, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t exp_c(int kk);
        return exp_out(kk, C_DIV, C_HA, C_HF, C_HS, C_HB, C_VA, C_VF, C_VS, C_VB);
    endfunction

    task automatic check(string name, obs_t got, obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h (hs,vs,von,pixel,line,tick,fs)",
                     name, k, got, want);
        end
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%0d want=%0d", name, k, got, want);
        end
    endtask

    task automatic check_all_reset(string name);
        check({name, "_a"}, obs_a, exp_a(0));
        check({name, "_b"}, obs_b, exp_b(0));
        check({name, "_c"}, obs_c, exp_c(0));
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            check("model_a", obs_a, exp_a(k));
            check("model_b", obs_b, exp_b(k));
            check("model_c", obs_c, exp_c(k));
            // Hand-derived points that pin the model itself.
            if (k == 1) begin
                check_val("a_first_tick_low", 32'(if_a.pix_tick), 32'd0);
                check_val("a_first_von", 32'(if_a.video_on), 32'd1);
                check_val("a_first_pixel", 32'(if_a.pixel), 32'd0);
            end
            if (k == 2) begin
                check_val("a_tick_clk2", 32'(if_a.pix_tick), 32'd1);
                check_val("a_pixel_clk2", 32'(if_a.pixel), 32'd1);
            end
            if (k == 449) check_val("a_vsync_pre", 32'(if_a.vsync), 32'd1);
            if (k == 450) check_val("a_vsync_start", 32'(if_a.vsync), 32'd0);
            if (k == 549) check_val("a_vsync_last", 32'(if_a.vsync), 32'd0);
            if (k == 550) check_val("a_vsync_end", 32'(if_a.vsync), 32'd1);
            if (k == 650 || k == 1300) begin
                check_val("a_frame_start", 32'(if_a.frame_start), 32'd1);
                check_val("a_wrap_von", 32'(if_a.video_on), 32'd1);
                check_val("a_wrap_line", 32'(if_a.line), 32'd0);
            end
            if (k == 651) check_val("a_frame_start_1clk", 32'(if_a.frame_start), 32'd0);
            if (k == 639) check_val("b_pixel_639", 32'(if_b.pixel), 32'd639);
            if (k == 640) begin
                check_val("b_von_fall", 32'(if_b.video_on), 32'd0);
                check_val("b_pixel_zero", 32'(if_b.pixel), 32'd0);
                check_val("c_frame_start", 32'(if_c.frame_start), 32'd1);
            end
            if (k == 655) check_val("b_hsync_pre", 32'(if_b.hsync), 32'd1);
            if (k == 656) check_val("b_hsync_start", 32'(if_b.hsync), 32'd0);
            if (k == 700) check_val("b_hsync_mid", 32'(if_b.hsync), 32'd0);
            if (k == 751) check_val("b_hsync_last", 32'(if_b.hsync), 32'd0);
            if (k == 752) check_val("b_hsync_end", 32'(if_b.hsync), 32'd1);
            if (k == 800) begin
                check_val("b_line1", 32'(if_b.line), 32'd1);
                check_val("b_line1_pixel", 32'(if_b.pixel), 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_reset("por");
        run_chk = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2200) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(20, 1500)) @(negedge clk);
            #($urandom_range(1, 3)) rst_n = 1'b0;
            #1 check_all_reset("async_rst");
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #2 rst_n = 1'b1;
        end

        // Abandon a line while hsync is low; reset must lift it without a clock edge.
        repeat (700) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_reset("rst_in_hsync");
        check_val("b_hsync_abandon", 32'(if_b.hsync), 32'd1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_timing.md
RASTER_TIMING -- requirements
Module: raster_timing

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 SHALL provide parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing, in lines.
REQ-004 SHALL provide parameter DIV, default 2, clk cycles per pixel (legal 1..4).
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 video_on  output  1  high while the raster is inside the active area.
REQ-010 pixel  output  10  active-area column, 0..H_ACTIVE-1, for the wall/ball raster consumers.
REQ-011 line  output  9  active-area row, 0..V_ACTIVE-1.
REQ-012 pix_tick  output  1  one-clk strobe marking each pixel step.
REQ-013 frame_start  output  1  one-clk strobe when the raster enters (0,0).

Function
REQ-014 SHALL assert pix_tick on one clk in every DIV clks; with DIV=1 it SHALL be constantly high after reset.
REQ-015 SHALL keep an internal 10-bit hcount, 0..H_TOTAL-1 (H_TOTAL=800), advancing only on pix_tick.
REQ-016 SHALL wrap hcount from H_TOTAL-1 to 0 and advance 10-bit vcount, 0..V_TOTAL-1 (V_TOTAL=525), on that same tick.
REQ-017 SHALL wrap vcount from V_TOTAL-1 to 0 on the tick that wraps hcount from 799 with vcount at 524; both wraps take effect on the same edge.
REQ-018 SHALL drive hsync low exactly while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
REQ-019 SHALL drive vsync low exactly while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
REQ-020 SHALL drive video_on high iff hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-021 SHALL drive pixel=hcount and line=vcount[8:0] while video_on is high, and 0 otherwise.
REQ-022 SHALL register all outputs and update them on the same edge as the counters (next-state decode), so all outputs are mutually aligned with zero lag relative to the counters.
REQ-023 SHALL pulse frame_start for the single clk on which the counters become (0,0).
REQ-024 SHALL hold hsync, vsync, video_on, pixel, line and frame_start stable between pix_tick edges.

Reset
REQ-025 On rst_n low the block SHALL immediately clear hcount, vcount and the divider.
REQ-026 On rst_n low the block SHALL drive hsync=1, vsync=1, video_on=0, pixel=0, line=0, pix_tick=0, frame_start=0.
REQ-027 The first pix_tick SHALL occur DIV clks after rst_n deasserts; counters SHALL start from (0,0) with no frame_start for that initial position.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no partial sync pulse held afterward.

Structure
REQ-029 A shared package SHALL hold the default timing constants and the derived H_TOTAL and V_TOTAL.
REQ-030 The divider SHALL be a sub-module pix_tick_gen (clk, rst_n, DIV -> pix_tick).
REQ-031 An elaboration check SHALL reject H_ACTIVE>1023, V_ACTIVE>511, or DIV outside 1..4.

Verification
REQ-032 Release reset with DIV=2: pix_tick on clk 2, 4, 6...; hcount 0->1 on clk 2; hsync=1, video_on=1, pixel=0, line=0.
REQ-033 Run one line: hsync low for exactly 96 ticks starting at hcount 656; video_on falls at hcount 640; pixel returns to 0.
REQ-034 Run one frame: vsync low for 2 full lines starting at vcount 490; exactly 800*525 ticks between consecutive frame_start pulses.
REQ-035 At hcount 799 / vcount 524, one tick: both counters are 0 on the same edge, frame_start is high for 1 clk, and line=0, pixel=0, video_on=1.
REQ-036 Assert rst_n low at hcount 700 (hsync low): hsync=1 and all counters 0 within the same clk, with no clk edge required.
REQ-037 Rebuild with DIV=1: pix_tick is constantly high and a frame takes 420000 clks.
